// File: rtl/vga_pmod_rx_pkg.sv
// Shared VGA timing, TinyVGA PMOD bit map and receiver state encoding.
// No ports; imported by the receiver and the sync generator side.
package vga_pmod_rx_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = 525;

    // pmod byte: {hs, B0, G0, R0, vs, B1, G1, R1}
    localparam int PMOD_HS = 7;
    localparam int PMOD_B0 = 6;
    localparam int PMOD_G0 = 5;
    localparam int PMOD_R0 = 4;
    localparam int PMOD_VS = 3;
    localparam int PMOD_B1 = 2;
    localparam int PMOD_G1 = 1;
    localparam int PMOD_R1 = 0;

    // both syncs deasserted, colour off
    localparam logic [7:0] PMOD_IDLE = 8'h88;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    function automatic logic [5:0] pmod_rgb(input logic [7:0] p);
        return {p[PMOD_R1], p[PMOD_R0],
                p[PMOD_G1], p[PMOD_G0],
                p[PMOD_B1], p[PMOD_B0]};
    endfunction

endpackage

// File: rtl/vga_pmod_rx_if.sv
// Decoded pixel stream and lock status leaving the PMOD receiver.
// master: receiver drives; slave: capture logic or monitor reads.
interface vga_pmod_rx_if;

    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [5:0] rgb;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [7:0] frame_cnt;

    modport master (
        output pix_valid, pix_x, pix_y, rgb,
        output frame_start, locked, sync_err, frame_cnt
    );

    modport slave (
        input pix_valid, pix_x, pix_y, rgb,
        input frame_start, locked, sync_err, frame_cnt
    );

endinterface

// File: rtl/vga_sync_edge.sv
// Registers the PMOD byte once and finds rising hsync/vsync edges.
// Ports: clk, rst_n, pmod_in -> pin_q, hs_rise, vs_rise.
module vga_sync_edge
    import vga_pmod_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pmod_in,
    output logic [7:0] pin_q,
    output logic       hs_rise,
    output logic       vs_rise
);

    logic hs_d;
    logic vs_d;

    // idle syncs at reset so release never looks like an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q <= PMOD_IDLE;
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
        end else begin
            pin_q <= pmod_in;
            hs_d  <= pin_q[PMOD_HS];
            vs_d  <= pin_q[PMOD_VS];
        end
    end

    assign hs_rise = pin_q[PMOD_HS] & ~hs_d;
    assign vs_rise = pin_q[PMOD_VS] & ~vs_d;

endmodule

// File: rtl/vga_pmod_rx.sv
// TinyVGA PMOD receiver: locks to VGA timing, rebuilds x/y and colour.
// Ports: clk, rst_n, pmod_in; pix (master) carries pixels and status.
module vga_pmod_rx #(
    parameter int H_ACTIVE = vga_pmod_rx_pkg::H_ACTIVE,
    parameter int H_BACK   = vga_pmod_rx_pkg::H_BACK,
    parameter int H_TOTAL  = vga_pmod_rx_pkg::H_TOTAL,
    parameter int V_ACTIVE = vga_pmod_rx_pkg::V_ACTIVE,
    parameter int V_BACK   = vga_pmod_rx_pkg::V_BACK,
    parameter int V_TOTAL  = vga_pmod_rx_pkg::V_TOTAL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pmod_in,
    vga_pmod_rx_if.master pix
);
    import vga_pmod_rx_pkg::*;

    localparam logic [9:0]  HB = 10'(H_BACK);
    localparam logic [9:0]  HE = 10'(H_BACK + H_ACTIVE);
    localparam logic [9:0]  VB = 10'(V_BACK);
    localparam logic [9:0]  VE = 10'(V_BACK + V_ACTIVE);
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [9:0]  VT = 10'(V_TOTAL);
    localparam logic [9:0]  CMAX = 10'h3ff;

    logic [7:0] pin_q;
    logic       hs_rise;
    logic       vs_rise;

    vga_sync_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pmod_in (pmod_in),
        .pin_q   (pin_q),
        .hs_rise (hs_rise),
        .vs_rise (vs_rise)
    );

    logic [9:0] hcnt, hcnt_nx;
    logic [9:0] vcnt, vcnt_nx;
    logic       bad, first;
    logic       line_bad, frame_bad;
    rx_state_t  st, st_nx;

    // next counts are the coordinates of the pixel now in pin_q
    always_comb begin
        hcnt_nx = (hcnt == CMAX) ? hcnt : hcnt + 10'd1;
        if (hs_rise) hcnt_nx = 10'd0;
        vcnt_nx = vcnt;
        unique case (1'b1)
            vs_rise && hs_rise:  vcnt_nx = 10'd1;
            vs_rise && !hs_rise: vcnt_nx = 10'd0;
            hs_rise && !vs_rise:
                vcnt_nx = (vcnt == CMAX) ? vcnt : vcnt + 10'd1;
            default: vcnt_nx = vcnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else begin
            hcnt <= hcnt_nx;
            vcnt <= vcnt_nx;
        end
    end

    // a saturated count after (re)entry says nothing about the line
    assign line_bad  = hs_rise
                     && !(first && hcnt == CMAX)
                     && ({1'b0, hcnt} + 11'd1 != HT);
    assign frame_bad = vs_rise && (vcnt != VT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_SEARCH;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            ST_SEARCH:
                if (vs_rise) st_nx = ST_MEASURE;
            ST_MEASURE:
                if (vs_rise && !bad && !line_bad && !frame_bad)
                    st_nx = ST_LOCKED;
            ST_LOCKED:
                if (line_bad || frame_bad) st_nx = ST_SEARCH;
            default: st_nx = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad   <= 1'b0;
            first <= 1'b0;
        end else begin
            if (vs_rise && st != ST_LOCKED)
                bad <= 1'b0;
            else if (line_bad && st == ST_MEASURE)
                bad <= 1'b1;
            if (st_nx != st && st_nx != ST_SEARCH)
                first <= 1'b1;
            else if (hs_rise)
                first <= 1'b0;
        end
    end

    logic       valid_d, fs_d, err_d;
    logic [9:0] x_d, y_d;
    logic [5:0] rgb_d;

    always_comb begin
        valid_d = (st_nx == ST_LOCKED)
                && hcnt_nx >= HB && hcnt_nx < HE
                && vcnt_nx >= VB && vcnt_nx < VE;
        x_d   = hcnt_nx - HB;
        y_d   = vcnt_nx - VB;
        rgb_d = valid_d ? pmod_rgb(pin_q) : 6'd0;
        fs_d  = valid_d && hcnt_nx == HB && vcnt_nx == VB;
        err_d = (st == ST_LOCKED) && (line_bad || frame_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.pix_valid   <= 1'b0;
            pix.pix_x       <= 10'd0;
            pix.pix_y       <= 10'd0;
            pix.rgb         <= 6'd0;
            pix.frame_start <= 1'b0;
            pix.sync_err    <= 1'b0;
            pix.frame_cnt   <= 8'd0;
        end else begin
            pix.pix_valid   <= valid_d;
            pix.pix_x       <= x_d;
            pix.pix_y       <= y_d;
            pix.rgb         <= rgb_d;
            pix.frame_start <= fs_d;
            pix.sync_err    <= err_d;
            pix.frame_cnt   <= pix.frame_cnt + {7'd0, fs_d};
        end
    end

    assign pix.locked = (st == ST_LOCKED);

endmodule

// File: tb/tb_vga_pmod_rx.sv
// Self-checking bench for vga_pmod_rx on a shrunken VGA raster.
// Drives PMOD bytes from a line/frame generator with random colour.
module tb_vga_pmod_rx;

    localparam int HA  = 10;
    localparam int HB  = 3;
    localparam int HT  = 20;
    localparam int HS0 = 16;
    localparam int VA  = 4;
    localparam int VB  = 2;
    localparam int VT  = 8;

    typedef struct packed {
        logic       v;
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] rgb;
        logic       fs;
        logic       err;
        logic       lk;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] pmod_in;

    vga_pmod_rx_if pix ();

    vga_pmod_rx #(
        .H_ACTIVE (HA),
        .H_BACK   (HB),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_BACK   (VB),
        .V_TOTAL  (VT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pmod_in (pmod_in),
        .pix     (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_err;
    int   rst_hold;
    exp_t e1, e2;

    // frame-level reference: 0 searching, 1 measuring, 2 locked
    int         m_st;
    bit         m_bad;
    int         m_lines;
    int         m_prev_len;
    logic [7:0] m_cnt;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input exp_t e);
        @(negedge clk);
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
        end
        chk("valid", 32'(pix.pix_valid), 32'(e2.v));
        chk("rgb", 32'(pix.rgb), 32'(e2.rgb));
        chk("frame_start", 32'(pix.frame_start), 32'(e2.fs));
        chk("sync_err", 32'(pix.sync_err), 32'(e2.err));
        chk("locked", 32'(pix.locked), 32'(e2.lk));
        if (e2.v) begin
            chk("pix_x", 32'(pix.pix_x), 32'(e2.x));
            chk("pix_y", 32'(pix.pix_y), 32'(e2.y));
        end
        e2 = e1;
        e1 = e;
        pmod_in = b;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix.pix_valid), 0);
        chk({tag, "_x"}, 32'(pix.pix_x), 0);
        chk({tag, "_y"}, 32'(pix.pix_y), 0);
        chk({tag, "_rgb"}, 32'(pix.rgb), 0);
        chk({tag, "_fs"}, 32'(pix.frame_start), 0);
        chk({tag, "_locked"}, 32'(pix.locked), 0);
        chk({tag, "_err"}, 32'(pix.sync_err), 0);
        chk({tag, "_fcnt"}, 32'(pix.frame_cnt), 0);
    endtask

    task automatic hs_event(inout logic err);
        m_lines++;
        if (m_st != 0 && m_prev_len != HT) begin
            if (m_st == 2) begin
                err  = 1'b1;
                m_st = 0;
            end else begin
                m_bad = 1'b1;
            end
        end
    endtask

    task automatic vs_event(inout logic err);
        if (m_st == 0) begin
            m_st  = 1;
            m_bad = 1'b0;
        end else if (m_st == 1) begin
            if (!m_bad && m_lines == VT) m_st = 2;
            m_bad = 1'b0;
        end else if (m_lines != VT) begin
            err  = 1'b1;
            m_st = 0;
        end
        m_lines = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        m_st     = 0;
        m_bad    = 1'b0;
        m_lines  = 0;
        m_cnt    = 8'd0;
        e1       = '0;
        e2       = '0;
        rst_hold = 3;
    endtask

    task automatic gen_line(input int l, input int len,
                            input bit rise, input int rst_hc);
        exp_t       e;
        logic       hs, vs, act;
        logic [1:0] r, g, b;
        for (int hc = 0; hc < len; hc++) begin
            if (hc == rst_hc) do_reset();
            hs  = (hc < HS0);
            vs  = !((l == VT - 1 && hc >= HS0) ||
                    (l == 0 && hc < HS0));
            act = l >= VB && l < VB + VA &&
                  hc >= HB && hc < HB + HA;
            r = act ? 2'($urandom_range(0, 3)) : 2'd0;
            g = act ? 2'($urandom_range(0, 3)) : 2'd0;
            b = act ? 2'($urandom_range(0, 3)) : 2'd0;
            e = '0;
            if (hc == 0 && rise) hs_event(e.err);
            if (l == 0 && hc == HS0) vs_event(e.err);
            e.lk  = (m_st == 2);
            e.v   = e.lk && act;
            e.x   = 10'(hc - HB);
            e.y   = 10'(l - VB);
            e.rgb = e.v ? {r, g, b} : 6'd0;
            e.fs  = e.v && hc == HB && l == VB;
            if (e.fs) m_cnt++;
            step({hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]}, e);
        end
        m_prev_len = len;
    endtask

    // mode 0 clean, 1 one stretched line, 2 one line short,
    // 3 reset pulse in a blanking line
    task automatic gen_frame(input int mode);
        int k;
        k = int'($urandom_range(1, 6));
        for (int l = 0; l < VT; l++) begin
            if (mode == 2 && l == 6) continue;
            gen_line(l,
                     (mode == 1 && l == k) ? HT + 1 : HT,
                     1'b1,
                     (mode == 3 && l == 6) ? 5 : -1);
        end
        chk("frame_cnt", 32'(pix.frame_cnt), 32'(m_cnt));
    endtask

    initial begin
        exp_t z;
        z          = '0;
        n_chk      = 0;
        n_err      = 0;
        rst_hold   = 0;
        e1         = '0;
        e2         = '0;
        m_st       = 0;
        m_bad      = 1'b0;
        m_lines    = 0;
        m_prev_len = 0;
        m_cnt      = 8'd0;
        pmod_in    = 8'hff;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle bus: no edges, never locks
        repeat (1100) step(8'hff, z);

        // lead-in line with vsync asserted, then clean frames
        gen_line(VT - 1, HT, 1'b0, -1);
        repeat (3) gen_frame(0);
        gen_frame(1);
        repeat (3) gen_frame(0);
        gen_frame(2);
        repeat (4) gen_frame(0);
        gen_frame(3);
        repeat (262) gen_frame(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
